// File: rtl/synth_pkg.sv
// Shared synthesizer output-stage definitions: DAC frame geometry, offset-binary constant and serializer FSM states.
package synth_pkg;

    localparam int DAC_SAMPLE_W = 24;
    localparam int DAC_FRAME_W  = 24;
    localparam int DAC_DATA_W   = 16;
    localparam int DAC_BITCNT_W = $clog2(DAC_FRAME_W);

    localparam logic [7:0]            DAC_CTRL_BYTE = 8'h00;
    localparam logic [DAC_DATA_W-1:0] DAC_OFFSET    = 16'h8000;

    typedef enum logic [1:0] {
        DAC_IDLE,
        DAC_LOAD,
        DAC_SHIFT
    } dac_state_t;

    // Two's-complement to offset-binary: flipping the sign bit adds 32768.
    function automatic logic [DAC_DATA_W-1:0] to_offset_binary(input logic [DAC_DATA_W-1:0] v);
        return v ^ DAC_OFFSET;
    endfunction

endpackage

// File: rtl/dac_sample_formatter.sv
// Converts the signed mixed sample to 16-bit offset-binary DAC data (window [SHIFT+15:SHIFT]).
// Optional clipping of out-of-range samples is enabled with the DAC_SATURATE_EN macro; otherwise overflow wraps.
module dac_sample_formatter
    import synth_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic signed [DAC_SAMPLE_W-1:0] i_sample,
    output logic        [DAC_DATA_W-1:0]   o_data
);

    logic signed [DAC_SAMPLE_W-1:0] w;

    assign w = i_sample >>> SHIFT;

`ifdef DAC_SATURATE_EN
    localparam logic signed [DAC_SAMPLE_W-1:0] W_MAX = 24'sd32767;
    localparam logic signed [DAC_SAMPLE_W-1:0] W_MIN = -24'sd32768;

    // NOTE: every output of a combinational block gets a default on entry so no path can infer a latch.
    always_comb begin
        o_data = to_offset_binary(w[DAC_DATA_W-1:0]);
        if (w > W_MAX) begin
            o_data = '1;
        end else if (w < W_MIN) begin
            o_data = '0;
        end
    end
`else
    logic unused_w_upper;

    assign o_data         = to_offset_binary(w[DAC_DATA_W-1:0]);
    assign unused_w_upper = ^w[DAC_SAMPLE_W-1:DAC_DATA_W];
`endif

endmodule

// File: rtl/dac_frame_serializer.sv
// Sample-rate timebase plus SPI shifter feeding a DAC8551-style converter with {ctrl byte, 16-bit data} frames.
// Build option: DAC_SATURATE_EN (clip instead of wrap in dac_sample_formatter).
module dac_frame_serializer
    import synth_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 1134,
    parameter int SHIFT         = 3
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic signed [DAC_SAMPLE_W-1:0] i_sample,
    output logic                           o_sample_strobe,
    output logic                           o_dac_sync_n,
    output logic                           o_dac_sclk,
    output logic                           o_dac_din,
    output logic                           o_busy
);

    localparam int TB_W = $clog2(SAMPLE_PERIOD);
    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("dac_frame_serializer: CLK_DIV must be >= 1");
    end
    if (SAMPLE_PERIOD < 48 * CLK_DIV + 4) begin : g_bad_period
        $error("dac_frame_serializer: SAMPLE_PERIOD too short for one frame");
    end
    if (SHIFT < 0 || SHIFT > 8) begin : g_bad_shift
        $error("dac_frame_serializer: SHIFT must be 0..8");
    end

    logic [TB_W-1:0]         tb_cnt;
    dac_state_t              state;
    logic [DAC_BITCNT_W-1:0] bit_cnt;
    logic [PH_W-1:0]         ph_cnt;
    logic signed [DAC_SAMPLE_W-1:0] sample_q;
    logic [DAC_FRAME_W-1:0]  frame_q;
    logic [DAC_DATA_W-1:0]   fmt_data;
    logic [DAC_FRAME_W-1:0]  frame_next;

    dac_sample_formatter #(
        .SHIFT (SHIFT)
    ) u_formatter (
        .i_sample (sample_q),
        .o_data   (fmt_data)
    );

    assign frame_next = {DAC_CTRL_BYTE, fmt_data};

    // Strobe is registered one count early so it is high exactly while tb_cnt == SAMPLE_PERIOD-1.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tb_cnt          <= '0;
            o_sample_strobe <= 1'b0;
        end else begin
            tb_cnt          <= (tb_cnt == TB_W'(SAMPLE_PERIOD - 1)) ? '0 : tb_cnt + 1'b1;
            o_sample_strobe <= (tb_cnt == TB_W'(SAMPLE_PERIOD - 2));
        end
    end

    // NOTE: pure datapath registers carry no reset; the FSM guarantees they are written before being used.
    always_ff @(posedge i_clk) begin
        if (state == DAC_IDLE && o_sample_strobe) begin
            sample_q <= i_sample;
        end
        if (state == DAC_LOAD) begin
            frame_q <= frame_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= DAC_IDLE;
            bit_cnt      <= '0;
            ph_cnt       <= '0;
            o_dac_sync_n <= 1'b1;
            o_dac_sclk   <= 1'b1;
            o_dac_din    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                DAC_IDLE: begin
                    if (o_sample_strobe) begin
                        state <= DAC_LOAD;
                    end
                end

                DAC_LOAD: begin
                    state        <= DAC_SHIFT;
                    bit_cnt      <= DAC_BITCNT_W'(DAC_FRAME_W - 1);
                    ph_cnt       <= '0;
                    o_dac_sync_n <= 1'b0;
                    o_dac_sclk   <= 1'b1;
                    o_dac_din    <= frame_next[DAC_FRAME_W-1];
                    o_busy       <= 1'b1;
                end

                DAC_SHIFT: begin
                    if (ph_cnt == PH_W'(CLK_DIV - 1)) begin
                        ph_cnt <= '0;
                        if (o_dac_sclk) begin
                            o_dac_sclk <= 1'b0;
                        end else if (bit_cnt == '0) begin
                            state        <= DAC_IDLE;
                            o_dac_sync_n <= 1'b1;
                            o_dac_sclk   <= 1'b1;
                            o_dac_din    <= 1'b0;
                            o_busy       <= 1'b0;
                        end else begin
                            // Next bit is presented on the rising edge, leaving the whole low phase stable.
                            o_dac_sclk <= 1'b1;
                            bit_cnt    <= bit_cnt - 1'b1;
                            o_dac_din  <= frame_q[bit_cnt-1'b1];
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= DAC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Scoreboard bench for dac_frame_serializer (CLK_DIV=2, SAMPLE_PERIOD=120, SHIFT=3); honours DAC_SATURATE_EN.
module tb_dac_frame_serializer;

    localparam int CLK_DIV  = 2;
    localparam int SP       = 120;
    localparam int FRAME_CY = 48 * CLK_DIV;

    logic        clk;
    logic        i_reset;
    logic signed [23:0] i_sample;
    logic        o_sample_strobe;
    logic        o_dac_sync_n;
    logic        o_dac_sclk;
    logic        o_dac_din;
    logic        o_busy;

    dac_frame_serializer #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SP),
        .SHIFT         (3)
    ) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_sample        (i_sample),
        .o_sample_strobe (o_sample_strobe),
        .o_dac_sync_n    (o_dac_sync_n),
        .o_dac_sclk      (o_dac_sclk),
        .o_dac_din       (o_dac_din),
        .o_busy          (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timebase model, independent of the DUT counter
    int m_cnt = 0;
    int since_rst = 0;
    always @(posedge clk) begin
        if (i_reset) begin
            m_cnt     <= 0;
            since_rst <= 0;
        end else begin
            m_cnt     <= (m_cnt == SP - 1) ? 0 : m_cnt + 1;
            since_rst <= since_rst + 1;
        end
    end

    logic [23:0] exp_q[$];

    // Monitor: decodes DIN on SCLK falling edges while SYNC_n is low
    bit          in_frame = 0;
    bit          first_pending = 1;
    bit          prev_sync = 1;
    bit          prev_sclk = 1;
    bit          held_din = 0;
    int          nbits = 0;
    int          low_len = 0;
    int          stab_err = 0;
    int          busy_err = 0;
    int          strobe_cyc = 0;
    logic [23:0] shreg = '0;
    logic [23:0] exp_frame;

    always @(negedge clk) begin
        if (i_reset) begin
            if (in_frame && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            in_frame      = 0;
            first_pending = 1;
            prev_sync     = 1;
            prev_sclk     = 1;
        end else begin
            if (o_sample_strobe || m_cnt == SP - 1) begin
                check("strobe_timing", 32'(o_sample_strobe), 32'(m_cnt == SP - 1));
                if (first_pending) begin
                    check("first_strobe_cycle", since_rst, SP - 1);
                    first_pending = 0;
                end
                strobe_cyc = since_rst;
            end
            if (!o_dac_sync_n && prev_sync) begin
                check("sync_delay", since_rst - strobe_cyc, 2);
                in_frame = 1;
                nbits    = 0;
                low_len  = 0;
                stab_err = 0;
                busy_err = 0;
                shreg    = '0;
            end
            if (!o_dac_sync_n) begin
                low_len++;
                if (!o_busy) busy_err++;
                if (!o_dac_sclk && prev_sclk) begin
                    shreg    = {shreg[22:0], o_dac_din};
                    held_din = o_dac_din;
                    nbits++;
                end else if (!o_dac_sclk && o_dac_din !== held_din) begin
                    stab_err++;
                end
            end
            if (o_dac_sync_n && !prev_sync && in_frame) begin
                in_frame = 0;
                check("frame_bits", nbits, 24);
                check("sync_low_len", low_len, FRAME_CY);
                check("din_stable_low", stab_err, 0);
                check("busy_in_frame", busy_err, 0);
                check("idle_after_frame", {29'd0, o_dac_sclk, o_dac_din, o_busy}, 32'b100);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(shreg), 32'hFFFF_FFFF);
                end else begin
                    exp_frame = exp_q.pop_front();
                    check("frame_data", 32'(shreg), 32'(exp_frame));
                end
            end
            prev_sync = o_dac_sync_n;
            prev_sclk = o_dac_sclk;
        end
    end

    // Holds s (or random data when jitter is set) until the modelled strobe cycle, then queues the expected frame.
    task automatic send(input logic [23:0] s, input logic [23:0] exp, input bit jitter);
        bit got = 0;
        for (int n = 0; n < 2 * SP && !got; n++) begin
            @(negedge clk);
            if (m_cnt == SP - 1) begin
                i_sample = s;
                exp_q.push_back(exp);
                got = 1;
            end else begin
                i_sample = jitter ? 24'($urandom) : s;
            end
        end
        if (!got) check("strobe_wait_timeout", 0, 1);
        if (jitter) begin
            repeat (5) begin
                @(negedge clk);
                i_sample = 24'($urandom);
            end
        end
    endtask

    initial begin
        bit seen;
        i_reset  = 1'b1;
        i_sample = '0;
        repeat (2) @(negedge clk);
        #1 i_reset = 1'b0;

        send(24'h000000, 24'h008000, 0);
        send(24'h000008, 24'h008001, 0);
        send(24'hFFFFF8, 24'h007FFF, 0);
        send(24'h03FFF8, 24'h00FFFF, 0);
`ifdef DAC_SATURATE_EN
        send(24'h100000, 24'h00FFFF, 0);
        send(24'hF00000, 24'h000000, 0);
`else
        send(24'h100000, 24'h008000, 0);
        send(24'hF00000, 24'h008000, 0);
`endif
        send(24'h012340, 24'h00A468, 0);
        send(24'h000010, 24'h008002, 1);
        send(24'hFEDCB8, 24'h005B97, 1);

        // Reset ten bits into a frame
        send(24'h012340, 24'h00A468, 0);
        seen = 0;
        for (int n = 0; n < 2 * SP && !seen; n++) begin
            @(negedge clk);
            if (o_dac_sync_n === 1'b0) seen = 1;
        end
        if (!seen) check("sync_wait_timeout", 0, 1);
        repeat (10 * 2 * CLK_DIV) @(negedge clk);
        #1 i_reset = 1'b1;
        @(negedge clk);
        check("reset_midframe", {28'd0, o_dac_sync_n, o_dac_sclk, o_dac_din, o_busy}, 32'b1100);
        #1 i_reset = 1'b0;

        send(24'hFEDCB8, 24'h005B97, 0);
        send(24'h000000, 24'h008000, 0);

        for (int n = 0; n < 2 * SP && (exp_q.size() != 0 || in_frame); n++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
